adder_arb_seq: RTL

ADDER_ARB_SEQ -- requirements
Module: adder_arb_seq

---
 rtl/adder_arb_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/adder_arb_seq.sv
// ---------------------------------------------------------------------------
// adder_arb_seq
//
// Two-requester, byte-serial 32-bit adder. One requester is granted in IDLE
// and its operands are captured. The sum is then built one byte per cycle
// with an 8-bit carry-lookahead slice, and the result is presented on a
// valid/ready response port.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration between the requesters
//              undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   reqN_valid / reqN_ready           request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin          request operands
//   rsp_valid / rsp_ready             response handshake
//   rsp_sum, rsp_cout, rsp_id         result and owning requester
//   busy                              high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module adder_arb_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        cin_q;
    logic        id_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        carry_q;
    logic [1:0]  idx_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_sum_q;
    logic        rsp_cout_q;
    logic        rsp_id_q;
    logic        busy_q;
`ifdef ARB_RR_EN
    logic        last_grant_q;
`endif

    logic        gnt_id_s;
    logic        accept_s;
    logic [31:0] opa_s;
    logic [31:0] opb_s;
    logic        opc_s;
    logic [7:0]  a_byte_s;
    logic [7:0]  b_byte_s;
    logic        slice_cin_s;
    logic [8:0]  slice_s;

    // 8-bit carry-lookahead slice: returns {carry_out, sum[7:0]}.
    function automatic logic [8:0] cla8(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic       cin);
        logic [7:0] p;
        logic [7:0] g;
        logic [8:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    // Arbitration: pick which requester would be granted this cycle.
    always_comb begin
`ifdef ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        if (req0_valid && req1_valid) begin
            gnt_id_s = ~last_grant_q;
        end else begin
            gnt_id_s = ~req0_valid;
        end
`else
        if (req0_valid) begin
            gnt_id_s = 1'b0;
        end else begin
            gnt_id_s = 1'b1;
        end
`endif
    end

    // Accept only in IDLE and never while reset is held.
    assign accept_s   = reset_n && (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept_s & ~gnt_id_s;
    assign req1_ready = accept_s &  gnt_id_s;

    // Operand mux for the granted requester.
    always_comb begin
        if (gnt_id_s) begin
            opa_s = req1_a;
            opb_s = req1_b;
            opc_s = req1_cin;
        end else begin
            opa_s = req0_a;
            opb_s = req0_b;
            opc_s = req0_cin;
        end
    end

    // Current byte slice; slice 0 uses the captured carry-in.
    assign a_byte_s    = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte_s    = b_q[{idx_q, 3'b000} +: 8];
    assign slice_cin_s = (idx_q == 2'd0) ? cin_q : carry_q;
    assign slice_s     = cla8(a_byte_s, b_byte_s, slice_cin_s);

    // Accumulator with the current slice result merged into its byte lane.
    always_comb begin
        acc_d = acc_q;
        acc_d[{idx_q, 3'b000} +: 8] = slice_s[7:0];
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            cin_q        <= 1'b0;
            id_q         <= 1'b0;
            acc_q        <= 32'd0;
            carry_q      <= 1'b0;
            idx_q        <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= 32'd0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_q          <= opa_s;
                        b_q          <= opb_s;
                        cin_q        <= opc_s;
                        id_q         <= gnt_id_s;
                        idx_q        <= 2'd0;
                        busy_q       <= 1'b1;
                        state_q      <= CALC;
`ifdef ARB_RR_EN
                        last_grant_q <= gnt_id_s;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_s[8];
                    idx_q   <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Last slice: publish straight from the merged accumulator.
                        rsp_sum_q   <= acc_d;
                        rsp_cout_q  <= slice_s[8];
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule
